// File: rtl/pulse_layer_seq_if.sv
// Switch-matrix side of one pulse layer: start request in, status strobes and last-pass level out.
interface pulse_layer_seq_if;
  logic pulseEn;
  logic TriggerDelay;
  logic FbDelay;
  logic FallbackCatch;
  logic LayerEnd;
  logic LayerLast;

  modport master (
    output pulseEn,
    input  TriggerDelay, FbDelay, FallbackCatch, LayerEnd, LayerLast
  );

  modport slave (
    input  pulseEn,
    output TriggerDelay, FbDelay, FallbackCatch, LayerEnd, LayerLast
  );
endinterface

// File: rtl/pulse_layer_seq.sv
// Per-layer pulse sequencer: trigger delay, pulse, feedback delay, feedback window, repeated per start.
//   state     | meaning
//   IDLE      | waiting for pulseEn; config latched on accept
//   TRIG_WAIT | counting trigger delay
//   PULSE     | pulseOut high for the pulse width
//   FB_WAIT   | counting feedback delay
//   FB_WINDOW | watching feedback until caught or window expires
//   LAYER_END | one-cycle pass end; repeat or return to IDLE
module pulse_layer_seq #(
  parameter int DW = 16,
  parameter int RW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  pulse_layer_seq_if.slave io,
  input  logic          io_abort,
  input  logic          io_feedback,
  input  logic [DW-1:0] io_cfgTrigDelay,
  input  logic [DW-1:0] io_cfgPulseWidth,
  input  logic [DW-1:0] io_cfgFbDelay,
  input  logic [DW-1:0] io_cfgFbWindow,
  input  logic [RW-1:0] io_cfgRepeat,
  output logic          io_pulseOut,
  output logic          io_busy,
  output logic          io_dropStrobe,
  output logic [RW-1:0] io_passCount
);

  typedef enum logic [2:0] {
    IDLE, TRIG_WAIT, PULSE, FB_WAIT, FB_WINDOW, LAYER_END
  } state_t;

  state_t state, stateNext;
  logic [DW-1:0] cnt, cntNext, cntDec;
  logic [DW-1:0] trigDly, pulseW, fbDly, fbWin;
  logic [RW-1:0] rep, passNext, passInc;
  logic trigStb, fbStb, fallStb, dropStb;
  logic trigNext, fbNext, fallNext, dropNext, latchCfg;

  // Counters hold clamped cfg minus one so a zero field still yields one cycle.
  function automatic logic [DW-1:0] clampM1(input logic [DW-1:0] x);
    return (x == '0) ? '0 : x - DW'(1);
  endfunction

  assign cntDec  = cnt - DW'(1);
  assign passInc = (io_passCount == '1) ? io_passCount : io_passCount + RW'(1);

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    passNext  = io_passCount;
    trigNext  = 1'b0;
    fbNext    = 1'b0;
    fallNext  = 1'b0;
    latchCfg  = 1'b0;
    dropNext  = io.pulseEn && (state != IDLE);
    if (io_abort) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.pulseEn) begin
            stateNext = TRIG_WAIT;
            cntNext   = clampM1(io_cfgTrigDelay);
            passNext  = '0;
            latchCfg  = 1'b1;
          end
        end
        TRIG_WAIT: begin
          if (cnt == '0) begin
            stateNext = PULSE;
            cntNext   = pulseW;
            trigNext  = 1'b1;
          end else begin
            cntNext = cntDec;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            stateNext = FB_WAIT;
            cntNext   = fbDly;
          end else begin
            cntNext = cntDec;
          end
        end
        FB_WAIT: begin
          if (cnt == '0) begin
            stateNext = FB_WINDOW;
            cntNext   = fbWin;
            fbNext    = 1'b1;
          end else begin
            cntNext = cntDec;
          end
        end
        FB_WINDOW: begin
          if (io_feedback) begin
            stateNext = LAYER_END;
            cntNext   = '0;
            passNext  = passInc;
          end else if (cnt == '0) begin
            stateNext = LAYER_END;
            fallNext  = 1'b1;
            passNext  = passInc;
          end else begin
            cntNext = cntDec;
          end
        end
        LAYER_END: begin
          if (io_passCount < rep) begin
            stateNext = TRIG_WAIT;
            cntNext   = trigDly;
          end else begin
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      trigDly      <= '0;
      pulseW       <= '0;
      fbDly        <= '0;
      fbWin        <= '0;
      rep          <= '0;
      io_passCount <= '0;
      trigStb      <= 1'b0;
      fbStb        <= 1'b0;
      fallStb      <= 1'b0;
      dropStb      <= 1'b0;
    end else begin
      state        <= stateNext;
      cnt          <= cntNext;
      io_passCount <= passNext;
      trigStb      <= trigNext;
      fbStb        <= fbNext;
      fallStb      <= fallNext;
      dropStb      <= dropNext;
      if (latchCfg) begin
        trigDly <= clampM1(io_cfgTrigDelay);
        pulseW  <= clampM1(io_cfgPulseWidth);
        fbDly   <= clampM1(io_cfgFbDelay);
        fbWin   <= clampM1(io_cfgFbWindow);
        rep     <= (io_cfgRepeat == '0) ? RW'(1) : io_cfgRepeat;
      end
    end
  end

  assign io_pulseOut      = (state == PULSE);
  assign io_busy          = (state != IDLE);
  assign io_dropStrobe    = dropStb;
  assign io.TriggerDelay  = trigStb;
  assign io.FbDelay       = fbStb;
  assign io.FallbackCatch = fallStb;
  assign io.LayerEnd      = (state == LAYER_END);
  // In LAYER_END the pass count already includes the finishing pass.
  assign io.LayerLast     = (state == LAYER_END) ? (io_passCount >= rep) :
                            ((state != IDLE) &&
                             (({1'b0, io_passCount} + (RW+1)'(1)) >= {1'b0, rep}));

endmodule
